// File: rtl/calc2_port_responder_if.sv
// calc2_port_responder_if: calc2 request/response port bundle between requester and responder
interface calc2_port_responder_if;
    logic [3:0]  req_cmd_in;
    logic [31:0] req_data_in;
    logic [1:0]  req_tag_in;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic [1:0]  out_tag;
    logic        drop_err;
    modport master (
        output req_cmd_in, req_data_in, req_tag_in,
        input  out_resp, out_data, out_tag, drop_err
    );
    modport slave (
        input  req_cmd_in, req_data_in, req_tag_in,
        output out_resp, out_data, out_tag, drop_err
    );
endinterface

// File: rtl/calc2_port_responder.sv
// calc2_port_responder: one calc2 port; queues two-cycle requests, executes in order, returns tagged results
module calc2_port_responder #(
    parameter int DEPTH     = 4,
    parameter int SHIFT_LAT = 3
) (
    input logic                   clk,
    input logic                   reset,
    calc2_port_responder_if.slave port
);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(SHIFT_LAT + 1);

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  tag;
        logic [31:0] op1;
        logic [31:0] op2;
    } entry_t;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state, state_nx;
    entry_t        mem [DEPTH];
    entry_t        cur, head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] count;
    logic [CW-1:0] cnt;
    logic          cap_pend;
    logic [3:0]    cap_cmd;
    logic [1:0]    cap_tag;
    logic [31:0]   cap_op1;
    logic          push, pop, done;
    logic [32:0]   sum;
    logic [1:0]    res_resp;
    logic [31:0]   res_data;

    assign head = mem[rd_ptr];
    // a full FIFO still accepts when the head leaves on the same edge
    assign push = cap_pend && (count != NW'(DEPTH) || pop);

    always_comb begin
        pop      = state != EXEC && count != '0;
        done     = state == EXEC && cnt == CW'(1);
        state_nx = pop ? EXEC : done ? RESP : state == RESP ? IDLE : state;
    end

    always_comb begin
        sum      = {1'b0, cur.op1} + {1'b0, cur.op2};
        res_resp = cur.cmd == 4'd1 ? (sum[32] ? 2'd2 : 2'd1) :
                   cur.cmd == 4'd2 ? (cur.op1 < cur.op2 ? 2'd2 : 2'd1) :
                   (cur.cmd == 4'd5 || cur.cmd == 4'd6) ? 2'd1 : 2'd2;
        res_data = res_resp != 2'd1 ? '0 :
                   cur.cmd == 4'd1 ? sum[31:0] :
                   cur.cmd == 4'd2 ? cur.op1 - cur.op2 :
                   cur.cmd == 4'd5 ? cur.op1 << cur.op2[4:0] : cur.op1 >> cur.op2[4:0];
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {cap_cmd, cap_tag, cap_op1, port.req_data_in};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_pend      <= 1'b0;
            cap_cmd       <= '0;
            cap_tag       <= '0;
            cap_op1       <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            cnt           <= '0;
            cur           <= '0;
            port.drop_err <= 1'b0;
            port.out_resp <= '0;
            port.out_data <= '0;
            port.out_tag  <= '0;
        end else begin
            cap_pend <= !cap_pend && port.req_cmd_in != '0;
            if (!cap_pend) begin
                cap_cmd <= port.req_cmd_in;
                cap_tag <= port.req_tag_in;
                cap_op1 <= port.req_data_in;
            end
            wr_ptr        <= wr_ptr + PW'(push);
            rd_ptr        <= rd_ptr + PW'(pop);
            count         <= count + NW'(push) - NW'(pop);
            port.drop_err <= cap_pend && !push;
            if (pop) begin
                cur <= head;
                cnt <= (head.cmd == 4'd5 || head.cmd == 4'd6) ? CW'(SHIFT_LAT) : CW'(1);
            end else if (state == EXEC) begin
                cnt <= cnt - CW'(1);
            end
            port.out_resp <= done ? res_resp : '0;
            port.out_data <= done ? res_data : '0;
            port.out_tag  <= done ? cur.tag : '0;
        end
    end
endmodule

// File: tb/tb_calc2_port_responder.sv
// tb_calc2_port_responder: randomized and directed checks against a timing/arithmetic reference model
module tb_calc2_port_responder;
    localparam int DEPTH     = 4;
    localparam int SHIFT_LAT = 3;

    typedef struct {
        int          edge_n;
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0, checks = 0, failures = 0, last_r = -100;
    ev_t  exp_q[$], obs_q[$];
    ev_t  mon_ev;
    int   exp_drop[$], obs_drop[$], push_at[$], pop_at[$];

    calc2_port_responder_if bus();

    calc2_port_responder #(.DEPTH(DEPTH), .SHIFT_LAT(SHIFT_LAT)) dut (
        .clk  (clk),
        .reset(reset),
        .port (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // every non-zero output cycle and every drop pulse is logged with the edge that produced it
    always @(negedge clk)
        if (!reset) begin
            if (bus.out_resp != 2'd0 || bus.out_data != 32'd0 || bus.out_tag != 2'd0) begin
                mon_ev.edge_n = cyc;
                mon_ev.resp   = bus.out_resp;
                mon_ev.data   = bus.out_data;
                mon_ev.tag    = bus.out_tag;
                obs_q.push_back(mon_ev);
            end
            if (bus.drop_err) obs_drop.push_back(cyc);
        end

    function automatic ev_t ref_calc(input int r, input logic [3:0] cmd, input logic [1:0] tag,
                                     input logic [31:0] a, input logic [31:0] b);
        ev_t    ev;
        longint s;
        s         = longint'(a) + longint'(b);
        ev.edge_n = r;
        ev.tag    = tag;
        ev.resp   = 2'd1;
        ev.data   = 32'd0;
        if (cmd == 4'd1) begin
            if (s > 64'hFFFF_FFFF) ev.resp = 2'd2;
            else ev.data = 32'(s);
        end else if (cmd == 4'd2) begin
            if (a < b) ev.resp = 2'd2;
            else ev.data = a - b;
        end else if (cmd == 4'd5) ev.data = a << (b % 32);
        else if (cmd == 4'd6) ev.data = a >> (b % 32);
        else ev.resp = 2'd2;
        return ev;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.req_cmd_in  = 4'd0;
            bus.req_tag_in  = 2'($urandom);
            bus.req_data_in = $urandom;
        end
    endtask

    // drives one request; operand cycle carries a junk command that must be ignored
    task automatic issue(input logic [3:0] cmd, input logic [1:0] tag, input logic [31:0] a, input logic [31:0] b);
        int e, n, p;
        bit pop_now;
        @(negedge clk);
        bus.req_cmd_in  = cmd;
        bus.req_tag_in  = tag;
        bus.req_data_in = a;
        e = cyc + 1;
        @(negedge clk);
        bus.req_cmd_in  = 4'($urandom_range(15, 1));
        bus.req_tag_in  = 2'($urandom);
        bus.req_data_in = b;
        n = 0;
        pop_now = 1'b0;
        foreach (pop_at[j]) begin
            if (push_at[j] <= e && pop_at[j] > e) n++;
            if (pop_at[j] == e + 1) pop_now = 1'b1;
        end
        if (n < DEPTH || pop_now) begin
            p = (e + 2 > last_r + 1) ? e + 2 : last_r + 1;
            last_r = p + ((cmd == 4'd5 || cmd == 4'd6) ? SHIFT_LAT : 1);
            push_at.push_back(e + 1);
            pop_at.push_back(p);
            exp_q.push_back(ref_calc(last_r, cmd, tag, a, b));
        end else begin
            exp_drop.push_back(e + 1);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        obs_q.delete();
        exp_drop.delete();
        obs_drop.delete();
        push_at.delete();
        pop_at.delete();
    endtask

    task automatic drain();
        idle((last_r > cyc ? last_r - cyc : 0) + 4);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_cmd_in  = 4'd1;
        bus.req_tag_in  = 2'd3;
        bus.req_data_in = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_resp !== 2'd0) begin failures++; $display("FAIL reset out_resp: got %0d want 0", bus.out_resp); end
        checks++;
        if (bus.out_data !== 32'd0) begin failures++; $display("FAIL reset out_data: got %h want 0", bus.out_data); end
        checks++;
        if (bus.out_tag !== 2'd0) begin failures++; $display("FAIL reset out_tag: got %0d want 0", bus.out_tag); end
        checks++;
        if (bus.drop_err !== 1'b0) begin failures++; $display("FAIL reset drop_err: got %b want 0", bus.drop_err); end
        bus.req_cmd_in = 4'd0;
        reset  = 1'b0;
        last_r = -100;
        clear_model();
    endtask

    task automatic test_arith();
        logic [3:0]  tc [8] = '{4'd1, 4'd1, 4'd2, 4'hC, 4'd5, 4'd6, 4'd2, 4'd1};
        logic [1:0]  tt [8] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd2, 2'd1, 2'd0};
        logic [31:0] ta [8] = '{32'h5, 32'hFFFF_FFFF, 32'h3, 32'h1234_5678, 32'h8000_0001, 32'h8000_0000, 32'h10, 32'hFFFF_FFFE};
        logic [31:0] tb [8] = '{32'h3, 32'h1, 32'h5, 32'h9, 32'h21, 32'd31, 32'h10, 32'h1};
        bit drop_ok;
        for (int i = 0; i < 8; i++) begin
            issue(tc[i], tt[i], ta[i], tb[i]);
            idle(7);
        end
        drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL arith resp_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i].edge_n != exp_q[i].edge_n || obs_q[i].resp !== exp_q[i].resp || obs_q[i].data !== exp_q[i].data || obs_q[i].tag !== exp_q[i].tag) begin
                failures++;
                $display("FAIL arith resp[%0d]: got edge %0d resp %0d data %h tag %0d, want edge %0d resp %0d data %h tag %0d", i,
                         obs_q[i].edge_n, obs_q[i].resp, obs_q[i].data, obs_q[i].tag, exp_q[i].edge_n, exp_q[i].resp, exp_q[i].data, exp_q[i].tag);
            end
        end
        checks++;
        drop_ok = obs_drop.size() == exp_drop.size();
        foreach (exp_drop[i]) if (drop_ok && obs_drop[i] != exp_drop[i]) drop_ok = 1'b0;
        if (!drop_ok) begin failures++; $display("FAIL arith drops: got %0d pulses want %0d", obs_drop.size(), exp_drop.size()); end
        clear_model();
    endtask

    task automatic test_back_to_back();
        bit drop_ok;
        issue(4'd5, 2'd0, $urandom, 32'($urandom_range(31, 0)));
        for (int i = 1; i <= 4; i++) issue(4'd1, 2'(i), 32'($urandom_range(1000, 0)), 32'($urandom_range(1000, 0)));
        idle(4);
        for (int i = 0; i < 10; i++) issue(4'd6, 2'(i), $urandom, $urandom);
        drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b resp_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i].edge_n != exp_q[i].edge_n || obs_q[i].resp !== exp_q[i].resp || obs_q[i].data !== exp_q[i].data || obs_q[i].tag !== exp_q[i].tag) begin
                failures++;
                $display("FAIL b2b resp[%0d]: got edge %0d resp %0d data %h tag %0d, want edge %0d resp %0d data %h tag %0d", i,
                         obs_q[i].edge_n, obs_q[i].resp, obs_q[i].data, obs_q[i].tag, exp_q[i].edge_n, exp_q[i].resp, exp_q[i].data, exp_q[i].tag);
            end
        end
        checks++;
        drop_ok = obs_drop.size() == exp_drop.size();
        foreach (exp_drop[i]) if (drop_ok && obs_drop[i] != exp_drop[i]) drop_ok = 1'b0;
        if (!drop_ok) begin failures++; $display("FAIL b2b drops: got %0d pulses want %0d", obs_drop.size(), exp_drop.size()); end
        clear_model();
    endtask

    task automatic test_random();
        bit          drop_ok;
        int          k;
        logic [3:0]  cmd;
        logic [31:0] a, b;
        repeat (40) begin
            idle($urandom_range(3, 0));
            k   = $urandom_range(7, 0);
            cmd = k < 2 ? 4'd1 : k < 4 ? 4'd2 : k == 4 ? 4'd5 : k == 5 ? 4'd6 : k == 6 ? 4'($urandom_range(15, 7)) : 4'd3;
            a   = $urandom_range(3, 0) == 0 ? 32'hFFFF_FFFF - 32'($urandom_range(3, 0)) : $urandom;
            b   = k[0] ? 32'($urandom_range(40, 0)) : $urandom;
            issue(cmd, 2'($urandom), a, b);
        end
        drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL random resp_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i].edge_n != exp_q[i].edge_n || obs_q[i].resp !== exp_q[i].resp || obs_q[i].data !== exp_q[i].data || obs_q[i].tag !== exp_q[i].tag) begin
                failures++;
                $display("FAIL random resp[%0d]: got edge %0d resp %0d data %h tag %0d, want edge %0d resp %0d data %h tag %0d", i,
                         obs_q[i].edge_n, obs_q[i].resp, obs_q[i].data, obs_q[i].tag, exp_q[i].edge_n, exp_q[i].resp, exp_q[i].data, exp_q[i].tag);
            end
        end
        checks++;
        drop_ok = obs_drop.size() == exp_drop.size();
        foreach (exp_drop[i]) if (drop_ok && obs_drop[i] != exp_drop[i]) drop_ok = 1'b0;
        if (!drop_ok) begin failures++; $display("FAIL random drops: got %0d pulses want %0d", obs_drop.size(), exp_drop.size()); end
        clear_model();
    endtask

    task automatic test_reset_mid();
        ev_t want;
        issue(4'd5, 2'd0, $urandom, $urandom);
        issue(4'd5, 2'd1, $urandom, $urandom);
        issue(4'd1, 2'd2, 32'd7, 32'd9);
        issue(4'd1, 2'd3, 32'd4, 32'd4);
        // land inside the second shift's execute window with two adds still queued
        idle(pop_at[1] + 2 - cyc);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.out_resp !== 2'd0 || bus.out_data !== 32'd0 || bus.out_tag !== 2'd0 || bus.drop_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_exec outputs: got resp %0d data %h tag %0d drop %b want all 0", bus.out_resp, bus.out_data, bus.out_tag, bus.drop_err);
        end
        clear_model();
        last_r = -100;
        idle(2);
        @(posedge clk);
        #2 reset = 1'b0;
        issue(4'd1, 2'd2, 32'($urandom_range(5000, 0)), 32'($urandom_range(5000, 0)));
        drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL reset_mid resp_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i].edge_n != exp_q[i].edge_n || obs_q[i].resp !== exp_q[i].resp || obs_q[i].data !== exp_q[i].data || obs_q[i].tag !== exp_q[i].tag) begin
                failures++;
                $display("FAIL reset_mid resp[%0d]: got edge %0d resp %0d data %h tag %0d, want edge %0d resp %0d data %h tag %0d", i,
                         obs_q[i].edge_n, obs_q[i].resp, obs_q[i].data, obs_q[i].tag, exp_q[i].edge_n, exp_q[i].resp, exp_q[i].data, exp_q[i].tag);
            end
        end
        clear_model();
        issue(4'd1, 2'd1, 32'($urandom_range(5000, 0)), 32'($urandom_range(5000, 0)));
        want = exp_q[0];
        idle(last_r - cyc);
        checks++;
        if (bus.out_resp !== want.resp || bus.out_data !== want.data || bus.out_tag !== want.tag) begin
            failures++;
            $display("FAIL pre_reset_resp: got resp %0d data %h tag %0d want resp %0d data %h tag %0d",
                     bus.out_resp, bus.out_data, bus.out_tag, want.resp, want.data, want.tag);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.out_resp !== 2'd0 || bus.out_data !== 32'd0 || bus.out_tag !== 2'd0) begin
            failures++;
            $display("FAIL reset_resp outputs: got resp %0d data %h tag %0d want all 0", bus.out_resp, bus.out_data, bus.out_tag);
        end
        idle(2);
        reset  = 1'b0;
        last_r = -100;
        clear_model();
    endtask

    initial begin
        bus.req_cmd_in  = 4'd0;
        bus.req_tag_in  = 2'd0;
        bus.req_data_in = 32'd0;
        test_reset();
        test_arith();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
